instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 55 +++++
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer_watchdog.sv | 41 ++++
 rtl/instr_sequencer.sv | 175 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared sequencer definitions: instruction fields, opcodes, FSM states and
// the mapping from opcode to the execution unit that services it.
package cnn_ctrl_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 28;
  localparam int OPC_W     = 4;
  localparam int OPERAND_W = 28;

  localparam logic [OPC_W-1:0] OP_NOP    = 4'd0;
  localparam logic [OPC_W-1:0] OP_LOAD_W = 4'd1;
  localparam logic [OPC_W-1:0] OP_LOAD_D = 4'd2;
  localparam logic [OPC_W-1:0] OP_MAC    = 4'd3;
  localparam logic [OPC_W-1:0] OP_POOL   = 4'd4;
  localparam logic [OPC_W-1:0] OP_STORE  = 4'd5;
  localparam logic [OPC_W-1:0] OP_HALT   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FINISH = 3'd5
  } seq_state_e;

  typedef enum logic [1:0] {
    UNIT_NONE = 2'd0,
    UNIT_MEM  = 2'd1,
    UNIT_SA   = 2'd2,
    UNIT_POOL = 2'd3
  } unit_e;

  function automatic unit_e opcode_unit(input logic [OPC_W-1:0] opc);
    unit_e u;
    case (opc)
      OP_LOAD_W, OP_LOAD_D, OP_STORE: u = UNIT_MEM;
      OP_MAC:                         u = UNIT_SA;
      OP_POOL:                        u = UNIT_POOL;
      default:                        u = UNIT_NONE;
    endcase
    return u;
  endfunction

  function automatic logic opcode_legal(input logic [OPC_W-1:0] opc);
    logic ok;
    case (opc)
      OP_NOP, OP_LOAD_W, OP_LOAD_D, OP_MAC,
      OP_POOL, OP_STORE, OP_HALT: ok = 1'b1;
      default:                    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory read port plus the start/done handshakes of the three
// execution units, as seen from the sequencer (master) and the units (slave).
interface instr_sequencer_if
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic                 imem_rd_en;
  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_rdata;
  logic                 mem_start;
  logic                 sa_start;
  logic                 pool_start;
  logic [OPERAND_W-1:0] cmd_operand;
  logic                 mem_done;
  logic                 sa_done;
  logic                 pool_done;

  modport master (
    output imem_rd_en, imem_addr, mem_start, sa_start, pool_start, cmd_operand,
    input  imem_rdata, mem_done, sa_done, pool_done
  );

  modport slave (
    input  imem_rd_en, imem_addr, mem_start, sa_start, pool_start, cmd_operand,
    output imem_rdata, mem_done, sa_done, pool_done
  );
endinterface

// File: rtl/instr_sequencer_watchdog.sv
// Per-instruction WAIT watchdog: counts enabled cycles since the last clear
// and flags expiry on the TIMEOUT-th enabled cycle.
module seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_limit_s;

  assign at_limit_s = (cnt_q == CW'(TIMEOUT - 1));
  assign expired_o  = enable_i && at_limit_s;

  // Next count: clear wins, then count up, holding once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {CW{1'b0}};
    end else if (enable_i && !at_limit_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches a run of instruction words, dispatches each
// to its execution unit and retires it on that unit's done pulse.
module instr_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic               s_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  initial_instruction_address,
  input  logic [CNT_W-1:0]   number_instrs,
  instr_sequencer_if.master  bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  pc,
  output logic [CNT_W-1:0]   instr_count
);

  seq_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   num_q, num_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               err_q, err_d;
  logic               busy_q, done_q, rd_en_q;
  logic               mem_start_q, sa_start_q, pool_start_q;

  logic [OPC_W-1:0]   opcode_s;
  unit_e              unit_s;
  unit_e              next_unit_s;
  logic               unit_done_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               last_s;
  logic               wd_clear_s, wd_enable_s, wd_expired_s;

  assign opcode_s    = ir_q[OPC_MSB:OPC_LSB];
  assign unit_s      = opcode_unit(opcode_s);
  assign next_unit_s = opcode_unit(ir_d[OPC_MSB:OPC_LSB]);
  assign cnt_inc_s   = cnt_q + CNT_W'(1);
  // A retiring HALT ends the run just like reaching the requested count.
  assign last_s      = (cnt_inc_s == num_q) || (opcode_s == OP_HALT);
  assign wd_enable_s = (state_q == ST_WAIT);
  assign wd_clear_s  = (state_q != ST_WAIT);

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk_i     (s_clk),
    .reset_i   (reset),
    .clear_i   (wd_clear_s),
    .enable_i  (wd_enable_s),
    .expired_o (wd_expired_s)
  );

  // Only the done of the unit the current instruction was dispatched to counts.
  always_comb begin
    unit_done_s = 1'b0;
    case (unit_s)
      UNIT_MEM:  unit_done_s = bus.mem_done;
      UNIT_SA:   unit_done_s = bus.sa_done;
      UNIT_POOL: unit_done_s = bus.pool_done;
      default:   unit_done_s = 1'b0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    ir_d    = ir_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = initial_instruction_address;
          cnt_d   = {CNT_W{1'b0}};
          num_d   = number_instrs;
          err_d   = 1'b0;
          state_d = (number_instrs == {CNT_W{1'b0}}) ? ST_FINISH : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        ir_d    = bus.imem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (!opcode_legal(opcode_s)) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else if (unit_s == UNIT_NONE) begin
          cnt_d = cnt_inc_s;
          if (last_s) begin
            state_d = ST_FINISH;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A matching done on the expiry cycle still retires the instruction.
        if (unit_done_s) begin
          cnt_d = cnt_inc_s;
          if (last_s) begin
            state_d = ST_FINISH;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ST_FETCH;
          end
        end else if (wd_expired_s) begin
          err_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, datapath and status/strobe outputs, the latter decoded from the next state.
  always_ff @(posedge s_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= {ADDR_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      num_q        <= {CNT_W{1'b0}};
      ir_q         <= {INSTR_W{1'b0}};
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      mem_start_q  <= 1'b0;
      sa_start_q   <= 1'b0;
      pool_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      ir_q         <= ir_d;
      err_q        <= err_d;
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_FINISH);
      rd_en_q      <= (state_d == ST_FETCH);
      mem_start_q  <= (state_d == ST_EXEC) && (next_unit_s == UNIT_MEM);
      sa_start_q   <= (state_d == ST_EXEC) && (next_unit_s == UNIT_SA);
      pool_start_q <= (state_d == ST_EXEC) && (next_unit_s == UNIT_POOL);
    end
  end

  assign bus.imem_rd_en  = rd_en_q;
  assign bus.imem_addr   = pc_q;
  assign bus.mem_start   = mem_start_q;
  assign bus.sa_start    = sa_start_q;
  assign bus.pool_start  = pool_start_q;
  assign bus.cmd_operand = ir_q[OPERAND_W-1:0];
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = err_q;
  assign pc              = pc_q;
  assign instr_count     = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a cycle-loop unit/memory responder
// plus a program-level reference model of fetch order, dispatches and status.
module tb_instr_sequencer;
  localparam int TIMEOUT = 4096;

  logic        s_clk = 1'b0;
  logic        reset, start;
  logic [7:0]  init_addr;
  logic [15:0] n_instrs;
  logic        busy, done, error;
  logic [7:0]  pc;
  logic [15:0] instr_count;

  instr_sequencer_if #(.ADDR_W(8), .INSTR_W(32)) bus();

  instr_sequencer #(.ADDR_W(8), .CNT_W(16), .INSTR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .s_clk(s_clk), .reset(reset), .start(start),
    .initial_instruction_address(init_addr), .number_instrs(n_instrs),
    .bus(bus), .busy(busy), .done(done), .error(error),
    .pc(pc), .instr_count(instr_count)
  );

  always #5 s_clk = ~s_clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] imem [256];
  int  got_fetch[$];
  byte got_starts[$];
  int  done_iter, first_fetch_iter, first_start_iter;
  bit  busy_bad, aborted;
  int  exp_fetch[$];
  byte exp_starts[$];
  int  exp_count;
  bit  exp_err;
  logic [7:0] exp_pc;

  function automatic logic [31:0] word(input int opc);
    logic [31:0] w;
    w = $urandom;
    w[31:28] = 4'(opc);
    return w;
  endfunction

  // Program-level model: walk the instruction words by the sequencing rules.
  task automatic ref_run(input logic [7:0] addr, input logic [15:0] n);
    logic [7:0] p;
    logic [3:0] opc;
    int c;
    p = addr; c = 0; exp_err = 1'b0;
    exp_fetch.delete(); exp_starts.delete();
    while (c < int'(n)) begin
      exp_fetch.push_back(int'(p));
      opc = imem[p][31:28];
      if (opc == 4'd1 || opc == 4'd2 || opc == 4'd5) exp_starts.push_back("M");
      else if (opc == 4'd3) exp_starts.push_back("S");
      else if (opc == 4'd4) exp_starts.push_back("P");
      else if (opc != 4'd0 && opc != 4'd15) begin exp_err = 1'b1; break; end
      c++;
      if (opc == 4'd15 || c == int'(n)) break;
      p = p + 8'd1;
    end
    exp_count = c;
    exp_pc = p;
  endtask

  task automatic drive_done(input int unit);
    if (unit == 1) bus.mem_done = 1'b1;
    else if (unit == 2) bus.sa_done = 1'b1;
    else if (unit == 3) bus.pool_done = 1'b1;
  endtask

  // mode 0: matching done after delay (random stray dones); mode 1: matching done withheld.
  task automatic run_program(input logic [7:0] addr, input logic [15:0] n, input int fixed_delay,
                             input int mode, input bit hold_start, input int abort_at, input int budget);
    int iter, pend_unit, pend_delay, nstarts, s, u;
    bit done_sent, rdata_pend;
    logic [15:0] prev_cnt;
    logic [7:0] rdata_addr;
    got_fetch.delete(); got_starts.delete();
    done_iter = -1; first_fetch_iter = -1; first_start_iter = -1;
    busy_bad = 1'b0; aborted = 1'b0;
    pend_unit = 0; pend_delay = 0; nstarts = 0; done_sent = 1'b0; rdata_pend = 1'b0; rdata_addr = 8'd0;
    @(posedge s_clk); #1;
    init_addr = addr; n_instrs = n; start = 1'b1;
    prev_cnt = instr_count;
    iter = 0;
    while (done_iter < 0 && !aborted) begin
      @(posedge s_clk); #1;
      iter++;
      if (iter > budget) begin
        vectors++; miscompares++;
        $display("FAIL run_budget: no done within %0d cycles (addr %0h n %0d)", budget, addr, n);
        break;
      end
      if (hold_start) begin init_addr = 8'($urandom); n_instrs = 16'($urandom_range(0, 3)); end
      else start = 1'b0;
      bus.mem_done = 1'b0; bus.sa_done = 1'b0; bus.pool_done = 1'b0;
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (instr_count !== prev_cnt) begin
        if (pend_unit != 0) begin
          vectors++;
          if (!done_sent) begin
            miscompares++;
            $display("FAIL early_retire: instr_count went %0d -> %0d before the unit done", prev_cnt, instr_count);
          end
        end
        pend_unit = 0; prev_cnt = instr_count;
      end
      s = int'(bus.mem_start) + int'(bus.sa_start) + int'(bus.pool_start);
      if (s > 0) begin
        vectors++;
        if (s != 1 || bus.cmd_operand !== imem[rdata_addr][27:0]) begin
          miscompares++;
          $display("FAIL dispatch: %0d start pulses, operand %0h, required 1 pulse, operand %0h",
                   s, bus.cmd_operand, imem[rdata_addr][27:0]);
        end
        nstarts++;
        if (first_start_iter < 0) first_start_iter = iter;
        if (bus.mem_start) begin got_starts.push_back("M"); pend_unit = 1; end
        else if (bus.sa_start) begin got_starts.push_back("S"); pend_unit = 2; end
        else begin got_starts.push_back("P"); pend_unit = 3; end
        pend_delay = (fixed_delay > 0) ? fixed_delay : $urandom_range(1, 6);
        done_sent = 1'b0;
        if (mode == 0 && fixed_delay == 0 && $urandom_range(0, 1) == 1) drive_done(pend_unit);
      end else if (pend_unit != 0 && !done_sent) begin
        if (abort_at > 0 && nstarts == abort_at) begin
          reset = 1'b1; aborted = 1'b1;
        end else if (mode == 1) begin
          for (int k = 1; k <= 3; k++) if (k != pend_unit) drive_done(k);
        end else begin
          pend_delay--;
          if (pend_delay == 0) begin drive_done(pend_unit); done_sent = 1'b1; end
          else begin
            u = $urandom_range(1, 3);
            if (u != pend_unit) drive_done(u);
          end
        end
      end
      if (rdata_pend) begin bus.imem_rdata = imem[rdata_addr]; rdata_pend = 1'b0; end
      if (bus.imem_rd_en === 1'b1) begin
        got_fetch.push_back(int'(bus.imem_addr));
        if (first_fetch_iter < 0) first_fetch_iter = iter;
        rdata_addr = bus.imem_addr; rdata_pend = 1'b1; bus.imem_rdata = $urandom;
      end
      if (done === 1'b1) done_iter = iter;
    end
    start = 1'b0;
    bus.mem_done = 1'b0; bus.sa_done = 1'b0; bus.pool_done = 1'b0;
    vectors++;
    if (busy_bad) begin miscompares++; $display("FAIL busy_run: busy dropped during the run, required 1"); end
    if (done_iter >= 0) begin
      @(posedge s_clk); #1;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL done_pulse: after FINISH done=%b busy=%b, required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1;
    init_addr = 8'h5A; n_instrs = 16'd3;
    bus.imem_rdata = 32'd0; bus.mem_done = 1'b0; bus.sa_done = 1'b0; bus.pool_done = 1'b0;
    repeat (3) @(posedge s_clk);
    #1;
    vectors++;
    if ({busy, done, error} !== 3'b000) begin miscompares++; $display("FAIL reset_status: busy/done/error=%b required 000", {busy, done, error}); end
    vectors++;
    if (pc !== 8'd0 || instr_count !== 16'd0) begin miscompares++; $display("FAIL reset_pc_cnt: pc=%0h cnt=%0d required 0 0", pc, instr_count); end
    vectors++;
    if ({bus.imem_rd_en, bus.mem_start, bus.sa_start, bus.pool_start} !== 4'b0000 || bus.cmd_operand !== 28'd0) begin
      miscompares++; $display("FAIL reset_bus: strobes=%b operand=%0h required 0000 0",
                              {bus.imem_rd_en, bus.mem_start, bus.sa_start, bus.pool_start}, bus.cmd_operand);
    end
    start = 1'b0;
    @(posedge s_clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    imem[8'h10] = word(3); imem[8'h11] = word(4); imem[8'h12] = word(5);
    run_program(8'h10, 16'd3, 5, 0, 1'b0, 0, 200);
    vectors++;
    if (got_fetch.size() != 3 || got_fetch[0] != 'h10 || got_fetch[1] != 'h11 || got_fetch[2] != 'h12) begin
      miscompares++; $display("FAIL basic_fetch: %0d fetches, first %0h, required 10,11,12", got_fetch.size(), got_fetch[0]);
    end
    vectors++;
    if (got_starts.size() != 3 || got_starts[0] != "S" || got_starts[1] != "P" || got_starts[2] != "M") begin
      miscompares++; $display("FAIL basic_order: %0d unit starts, required sa,pool,mem", got_starts.size());
    end
    vectors++;
    if (first_fetch_iter != 1 || first_start_iter != 3 || done_iter != 25) begin
      miscompares++; $display("FAIL basic_latency: fetch@%0d start@%0d done@%0d required 1 3 25",
                              first_fetch_iter, first_start_iter, done_iter);
    end
    vectors++;
    if (instr_count !== 16'd3 || error !== 1'b0 || pc !== 8'h12) begin
      miscompares++; $display("FAIL basic_status: cnt=%0d err=%b pc=%0h required 3 0 12", instr_count, error, pc);
    end
  endtask

  task automatic test_zero_count;
    run_program(8'h33, 16'd0, 0, 0, 1'b0, 0, 20);
    vectors++;
    if (done_iter != 1 || got_fetch.size() != 0 || got_starts.size() != 0) begin
      miscompares++; $display("FAIL zero_count: done@%0d fetches=%0d starts=%0d required 1 0 0",
                              done_iter, got_fetch.size(), got_starts.size());
    end
    vectors++;
    if (instr_count !== 16'd0 || pc !== 8'h33) begin
      miscompares++; $display("FAIL zero_status: cnt=%0d pc=%0h required 0 33", instr_count, pc);
    end
  endtask

  task automatic test_wrap;
    imem[8'hFF] = word(0); imem[8'h00] = word(0);
    run_program(8'hFF, 16'd2, 0, 0, 1'b0, 0, 50);
    vectors++;
    if (got_fetch.size() != 2 || got_fetch[0] != 'hFF || got_fetch[1] != 'h00 || done_iter != 7) begin
      miscompares++; $display("FAIL wrap_fetch: %0d fetches, done@%0d, required FF,00 done@7", got_fetch.size(), done_iter);
    end
    vectors++;
    if (instr_count !== 16'd2 || pc !== 8'h00 || got_starts.size() != 0) begin
      miscompares++; $display("FAIL wrap_status: cnt=%0d pc=%0h starts=%0d required 2 00 0", instr_count, pc, got_starts.size());
    end
  endtask

  task automatic test_halt;
    imem[8'h40] = word(1); imem[8'h41] = word(15); imem[8'h42] = word(3);
    run_program(8'h40, 16'd5, 0, 0, 1'b0, 0, 100);
    vectors++;
    if (got_fetch.size() != 2 || got_starts.size() != 1 || instr_count !== 16'd2 || error !== 1'b0) begin
      miscompares++; $display("FAIL halt: fetches=%0d starts=%0d cnt=%0d err=%b required 2 1 2 0",
                              got_fetch.size(), got_starts.size(), instr_count, error);
    end
  endtask

  task automatic test_timeout;
    imem[8'h80] = word(3); imem[8'h81] = word(0);
    run_program(8'h80, 16'd2, 0, 1, 1'b0, 0, TIMEOUT + 100);
    vectors++;
    if (error !== 1'b1 || instr_count !== 16'd0 || done_iter != TIMEOUT + 4) begin
      miscompares++; $display("FAIL timeout: err=%b cnt=%0d done@%0d required 1 0 %0d",
                              error, instr_count, done_iter, TIMEOUT + 4);
    end
    vectors++;
    if (got_starts.size() != 1 || got_fetch.size() != 1) begin
      miscompares++; $display("FAIL timeout_trace: starts=%0d fetches=%0d required 1 1", got_starts.size(), got_fetch.size());
    end
  endtask

  task automatic test_reset_mid;
    bit bad;
    imem[8'h20] = word(2); imem[8'h21] = word(3); imem[8'h22] = word(4); imem[8'h23] = word(5);
    run_program(8'h20, 16'd4, 3, 0, 1'b0, 2, 200);
    @(posedge s_clk); #1;
    vectors++;
    if ({busy, done, error, bus.imem_rd_en, bus.mem_start, bus.sa_start, bus.pool_start} !== 7'd0 ||
        pc !== 8'd0 || instr_count !== 16'd0 || !aborted) begin
      miscompares++; $display("FAIL reset_mid: busy=%b done=%b pc=%0h cnt=%0d aborted=%b required all 0, aborted 1",
                              busy, done, pc, instr_count, aborted);
    end
    reset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge s_clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || bus.mem_start || bus.sa_start || bus.pool_start) bad = 1'b1;
    end
    vectors++;
    if (bad) begin miscompares++; $display("FAIL reset_quiet: activity after abort, required none"); end
    ref_run(8'h20, 16'd4);
    run_program(8'h20, 16'd4, 0, 0, 1'b0, 0, 200);
    vectors++;
    if (got_fetch.size() != exp_fetch.size() || instr_count !== 16'(exp_count) || error !== 1'b0) begin
      miscompares++; $display("FAIL rerun: fetches=%0d cnt=%0d err=%b required %0d %0d 0",
                              got_fetch.size(), instr_count, error, exp_fetch.size(), exp_count);
    end
  endtask

  task automatic test_random(input int runs, input bit hold);
    logic [7:0] a;
    logic [15:0] n;
    int r;
    bit same;
    for (int t = 0; t < runs; t++) begin
      for (int i = 0; i < 256; i++) begin
        r = $urandom_range(0, 15);
        if (r < 12) imem[i] = word(r % 6);
        else if (r < 14) imem[i] = word(15 - (r - 12) * 15);
        else if (r == 14) imem[i] = word(15);
        else imem[i] = word($urandom_range(6, 14));
      end
      a = 8'($urandom);
      n = 16'($urandom_range(1, 8));
      ref_run(a, n);
      run_program(a, n, 0, 0, hold, 0, 400);
      same = (got_fetch.size() == exp_fetch.size()) && (got_starts.size() == exp_starts.size());
      for (int i = 0; same && i < exp_fetch.size(); i++) if (got_fetch[i] != exp_fetch[i]) same = 1'b0;
      for (int i = 0; same && i < exp_starts.size(); i++) if (got_starts[i] != exp_starts[i]) same = 1'b0;
      vectors++;
      if (!same) begin
        miscompares++; $display("FAIL rand_trace: run %0d fetches=%0d starts=%0d required %0d %0d",
                                t, got_fetch.size(), got_starts.size(), exp_fetch.size(), exp_starts.size());
      end
      vectors++;
      if (instr_count !== 16'(exp_count) || error !== exp_err || pc !== exp_pc) begin
        miscompares++; $display("FAIL rand_status: run %0d cnt=%0d err=%b pc=%0h required %0d %b %0h",
                                t, instr_count, error, pc, exp_count, exp_err, exp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_wrap();
    test_halt();
    test_timeout();
    test_reset_mid();
    test_random(8, 1'b0);
    test_random(3, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
